// File: rtl/dircc_types_pkg.sv
// Shared types for the DIRCC device-state path: the status-register image, the updater
// opcode set and the updater FSM encoding.
package dircc_types_pkg;

  typedef struct packed {
    logic [15:0] dircc_state_extra;
    logic [15:0] dircc_state;
    logic [63:0] user_state;
  } device_state_t;

  typedef enum logic [1:0] {
    OP_SET_LO    = 2'd0,
    OP_SET_HI    = 2'd1,
    OP_ADD       = 2'd2,
    OP_SET_FLAGS = 2'd3
  } dircc_update_op_t;

  typedef enum logic [1:0] {
    UpdIdle    = 2'd0,
    UpdCapture = 2'd1,
    UpdCompute = 2'd2,
    UpdWrite   = 2'd3
  } dircc_upd_state_t;

endpackage

// File: rtl/dircc_state_updater_if.sv
// Message, status-register read and commit signals of the DIRCC state updater.
// The master drives update messages and the register image; the slave is the updater.
interface dircc_state_updater_if #(
  parameter int unsigned PAYLOAD_WIDTH = 32
);
  import dircc_types_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_opcode;
  logic [PAYLOAD_WIDTH-1:0] in_payload;
  device_state_t            read_state;
  logic                     ext_mem_write;
  device_state_t            write_state;
  logic                     write_state_valid;
  logic                     update_done;
  logic                     update_dropped;

  modport master (
    output in_valid, in_opcode, in_payload, read_state, ext_mem_write,
    input  in_ready, write_state, write_state_valid, update_done, update_dropped
  );

  modport slave (
    input  in_valid, in_opcode, in_payload, read_state, ext_mem_write,
    output in_ready, write_state, write_state_valid, update_done, update_dropped
  );

endinterface

// File: rtl/dircc_state_updater.sv
// Read-modify-write updater for the DIRCC status register: IDLE -> CAPTURE -> COMPUTE -> WRITE.
// Define DIRCC_UPDATER_STALL_TIMEOUT_EN to drop updates stalled in WRITE for STALL_LIMIT cycles.
module dircc_state_updater
  import dircc_types_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 32,
  parameter int unsigned STALL_LIMIT   = 255
) (
  input logic                  clk,
  input logic                  reset,
  dircc_state_updater_if.slave bus
);

  dircc_upd_state_t         state_q, state_d;
  dircc_update_op_t         op_q;
  logic [PAYLOAD_WIDTH-1:0] payload_q;
  device_state_t            cur_q;
  device_state_t            write_q;
  device_state_t            next_state;
  logic [63:0]              payload_ext;
  logic                     accept;
  logic                     commit;
  logic                     drop;

  assign accept      = (state_q == UpdIdle) && bus.in_valid;
  // A host write owns the register this cycle, so the commit waits for it to finish.
  assign commit      = (state_q == UpdWrite) && !bus.ext_mem_write;
  assign payload_ext = 64'(payload_q);

  always_comb begin
    next_state = cur_q;
    unique case (op_q)
      OP_SET_LO:    next_state.user_state[31:0]  = payload_ext[31:0];
      OP_SET_HI:    next_state.user_state[63:32] = payload_ext[31:0];
      OP_ADD:       next_state.user_state        = cur_q.user_state + payload_ext;
      OP_SET_FLAGS: next_state.dircc_state       = cur_q.dircc_state | payload_ext[15:0];
    endcase
    next_state.dircc_state_extra = cur_q.dircc_state_extra + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UpdIdle:    if (bus.in_valid) state_d = UpdCapture;
      UpdCapture: state_d = UpdCompute;
      UpdCompute: state_d = UpdWrite;
      UpdWrite:   if (commit || drop) state_d = UpdIdle;
    endcase
  end

`ifdef DIRCC_UPDATER_STALL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(STALL_LIMIT + 1);

  logic [CntW-1:0] stall_cnt_q;

  // Drop on the STALL_LIMIT-th consecutive stalled WRITE cycle.
  assign drop = (state_q == UpdWrite) && bus.ext_mem_write &&
                (stall_cnt_q == CntW'(STALL_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || (state_q != UpdWrite) || !bus.ext_mem_write) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UpdIdle;
      write_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == UpdCompute) write_q <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= dircc_update_op_t'(bus.in_opcode);
      payload_q <= bus.in_payload;
    end
    if (state_q == UpdCapture) cur_q <= bus.read_state;
  end

  assign bus.in_ready          = (state_q == UpdIdle);
  assign bus.write_state       = write_q;
  assign bus.write_state_valid = commit;
  assign bus.update_done       = commit;
  assign bus.update_dropped    = drop;

endmodule

// File: tb/tb_dircc_state_updater.sv
// Scoreboard bench for dircc_state_updater: directed updates push hand-computed results,
// a negedge monitor pops and checks them whenever the commit strobe fires.
module tb_dircc_state_updater;
  import dircc_types_pkg::*;

`ifdef DIRCC_UPDATER_STALL_TIMEOUT_EN
  localparam int unsigned StallLimit = 4;
  localparam bit          TimeoutEn  = 1'b1;
`else
  localparam int unsigned StallLimit = 255;
  localparam bit          TimeoutEn  = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dircc_state_updater_if #(.PAYLOAD_WIDTH(32)) bus ();

  dircc_state_updater #(
    .PAYLOAD_WIDTH(32),
    .STALL_LIMIT  (StallLimit)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    device_state_t st;
    int            acc;
    int            lat;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [31:0]   pl;
    device_state_t rs;
    device_state_t ex;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic device_state_t mk(logic [63:0] u, logic [15:0] f, logic [15:0] x);
    return '{dircc_state_extra: x, dircc_state: f, user_state: u};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Presents one message once in_ready is seen; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] pl, input device_state_t rs,
                       input bit push, input device_state_t ex, input int lat);
    int waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("in_ready_wait", 128'(bus.in_ready), 128'(1));
      return;
    end
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_payload = pl;
    bus.read_state = rs;
    if (push) exp_q.push_back('{ex, cyc, lat});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bus.write_state_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 128'(bus.write_state_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("write_state", 128'(bus.write_state), 128'(e.st));
          check("commit_latency", 128'(cyc - e.acc), 128'(e.lat));
          check("update_done", 128'(bus.update_done), 128'(1));
          check("no_drop_on_commit", 128'(bus.update_dropped), 128'(0));
        end
      end else if (bus.update_done) begin
        check("stray_update_done", 128'(bus.update_done), 128'(0));
      end
      if (bus.ext_mem_write) check("strobe_during_ext_write", 128'(bus.write_state_valid), 128'(0));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_opcode     = 2'd0;
    bus.in_payload    = '0;
    bus.read_state    = '0;
    bus.ext_mem_write = 1'b0;

    vecs[0] = '{2'd2, 32'h0000_0010, mk(64'h0, 16'h0000, 16'h0005),
                mk(64'h10, 16'h0000, 16'h0006)};
    vecs[1] = '{2'd2, 32'h0000_0001, mk(64'h0000_0000_FFFF_FFFF, 16'h0007, 16'h0001),
                mk(64'h0000_0001_0000_0000, 16'h0007, 16'h0002)};
    vecs[2] = '{2'd2, 32'h0000_0001, mk(64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 16'h0010),
                mk(64'h0, 16'h0000, 16'h0011)};
    vecs[3] = '{2'd3, 32'h0000_0003, mk(64'h1234, 16'h0100, 16'hFFFF),
                mk(64'h1234, 16'h0103, 16'h0000)};
    vecs[4] = '{2'd0, 32'h1122_3344, mk(64'hAAAA_BBBB_CCCC_DDDD, 16'h0005, 16'h0007),
                mk(64'hAAAA_BBBB_1122_3344, 16'h0005, 16'h0008)};
    vecs[5] = '{2'd1, 32'h5566_7788, mk(64'hAAAA_BBBB_CCCC_DDDD, 16'h0005, 16'h0007),
                mk(64'h5566_7788_CCCC_DDDD, 16'h0005, 16'h0008)};
    vecs[6] = '{2'd3, 32'hFFFF_0040, mk(64'h5, 16'h8001, 16'h0020),
                mk(64'h5, 16'h8041, 16'h0021)};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_write_state", 128'(bus.write_state), 128'(0));
    check("reset_valid", 128'(bus.write_state_valid), 128'(0));
    check("reset_done", 128'(bus.update_done), 128'(0));
    check("reset_dropped", 128'(bus.update_dropped), 128'(0));

    foreach (vecs[i]) issue(vecs[i].op, vecs[i].pl, vecs[i].rs, 1'b1, vecs[i].ex, 3);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    check("write_state_hold", 128'(bus.write_state), 128'(vecs[6].ex));

    // Host write covers the whole WRITE window: 10 stalled cycles, commit on the first free one.
    issue(2'd0, 32'hDEAD_BEEF, mk(64'h1111_2222_3333_4444, 16'h00F0, 16'h0042), !TimeoutEn,
          mk(64'h1111_2222_DEAD_BEEF, 16'h00F0, 16'h0043), 13);
    bus.ext_mem_write = 1'b1;
    for (int rel = 1; rel <= 12; rel++) begin
      @(negedge clk);
      check("stall_in_ready", 128'(bus.in_ready), 128'(TimeoutEn && rel >= 7));
      check("stall_dropped", 128'(bus.update_dropped), 128'(TimeoutEn && rel == 6));
      @(posedge clk);
    end
    #1 bus.ext_mem_write = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);

    // Reset lands while the update is in COMPUTE.
    issue(2'd2, 32'h0000_0005, mk(64'h77, 16'h0000, 16'h0000), 1'b0, '0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("post_reset_write_state", 128'(bus.write_state), 128'(0));
    check("post_reset_valid", 128'(bus.write_state_valid), 128'(0));
    repeat (5) @(posedge clk);

    issue(2'd1, 32'h0000_0001, mk(64'h0, 16'h0000, 16'hFFFE), 1'b1,
          mk(64'h0000_0001_0000_0000, 16'h0000, 16'hFFFF), 3);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
